sdram_slot_arbiter: RTL and testbench
=====================================

// Module: sdram_slot_arbiter
// PURPOSE
//  Shares the single per-clkref CPU access slot of the 2-channel SNES SDRAM controller among NUM_REQ requesters.
//  Port 0 is the SNES CPU/ROM/WRAM path and has absolute priority; ports 1..NUM_REQ-1 (BSRAM, RV softcore, loader) are round-robin.
//  One request is granted per clkref period and driven to the controller as a held rd/wr command.
//  Read data is routed back to the owner of the granted slot.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8); port 0 is fixed-priority
//  AW       23  word address width (addr[AW:1] of byte space)
//  DW       16  data width
// PORTS
//  clk             in   1          SDRAM clock, same domain as the controller
//  reset           in   1          asynchronous, active-high
//  clkref          in   1          slot reference, synchronous to clk; slot starts on its rising edge
//  req_valid       in   NUM_REQ    request pending; hold stable until req_ready
//  req_we          in   NUM_REQ    1=write, 0=read
//  req_addr        in   NUM_REQ*AW packed word addresses, port i at [i*AW +: AW]
//  req_din         in   NUM_REQ*DW packed write data
//  req_ds          in   NUM_REQ*2  packed byte enables {hi,lo}
//  req_ready       out  NUM_REQ    1-cycle accept pulse to the granted port
//  resp_valid      out  NUM_REQ    1-cycle read-data pulse to the owning port
//  resp_data       out  DW         read data; valid while resp_valid!=0, held otherwise
//  mem_rd, mem_wr  out  1 each     command to controller CPU channel, held for whole slot
//  mem_addr        out  AW         granted address
//  mem_din         out  DW         granted write data
//  mem_ds          out  2          granted byte enables
//  mem_dout        in   DW         controller read data
//  mem_dout_valid  in   1          1-cycle pulse when mem_dout is valid for the current slot
//  idle_slot       out  1          1-cycle pulse: slot started with no grant (refresh opportunity)
//  err_lost        out  1          sticky: a read slot ended without mem_dout_valid
// BEHAVIOUR
//  Reset (async): all outputs 0, resp_data=0, rr_ptr=1, state=IDLE, owner cleared.
//  Slot edge: edge = clkref & ~clkref_r (clkref_r registered). All decisions occur on edge cycle T; outputs registered, visible at T+1.
//  Arbitration at T, over req_valid sampled at T:
//   - req_valid[0] -> winner 0.
//   - else first valid port at or after rr_ptr among 1..NUM_REQ-1, wrapping NUM_REQ-1 -> 1.
//   - rr_ptr advances to winner+1 (wrap to 1) only when a port >=1 wins; unchanged when port 0 wins.
//  Grant (T+1): req_ready[winner]=1 for exactly one cycle; mem_rd=~we, mem_wr=we; mem_addr/din/ds loaded from winner.
//   - These hold until the next edge.
//  No winner at T: mem_rd=mem_wr=0 from T+1; idle_slot=1 at T+1 only.
//  States:
//   - IDLE: no command.
//   - WR: write slot held.
//   - RD_WAIT: read issued, awaiting data.
//   - RD_DONE: read data delivered.
//   - Transitions occur at each edge per the grant result.
//  In RD_WAIT, mem_dout_valid at cycle D -> resp_data=mem_dout and resp_valid[owner]=1 at D+1; state -> RD_DONE.
//  mem_dout_valid outside RD_WAIT: ignored, no resp_valid.
//  Edge while in RD_WAIT (data never arrived): err_lost<=1 (sticky until reset), no resp_valid, new arbitration proceeds normally.
//  mem_dout_valid and edge in same cycle while in RD_WAIT: data delivered (resp_valid at T+1), no error, new grant also at T+1.
//  A port whose request was accepted must not see req_ready again for that request; a new request may be raised the cycle after req_ready.
//  Writes produce no resp_valid; completion is implied by req_ready.
//  req_valid dropped before grant: simply not considered; no error.
//  Reset mid-slot: command dropped immediately; pending resp lost, no err_lost.
// TESTING
//  - Reset: assert reset mid-RD_WAIT -> all outputs 0 immediately, rr_ptr=1, err_lost=0 after release.
//  - Priority: req_valid=4'b0111 at edge -> req_ready=4'b0001 at T+1, mem_rd=1; rr_ptr stays 1; next edge with 4'b0110 -> port 1.
//  - Round-robin: ports 1,2,3 held valid for 6 slots, port 0 idle -> grant order 1,2,3,1,2,3.
//  - Read return: port 2 read addr 23'h1234, mem_dout=16'hBEEF pulsed 4 cycles after edge -> resp_valid=4'b0100, resp_data=16'hBEEF one cycle later.
//  - Lost data: read granted, no mem_dout_valid before next edge -> err_lost=1 and stays 1.
//  - Idle/refresh: no req_valid at edge -> idle_slot pulses 1 cycle, mem_rd=mem_wr=0.
//  - Coincident: mem_dout_valid on edge cycle -> both resp_valid and new req_ready at T+1, err_lost=0.

Source files
------------

// File: rtl/sdram_slot_arbiter.sv
// Per-clkref slot arbiter for the SDRAM controller CPU channel: port 0 has absolute
// priority, the remaining ports share slots round-robin, read data returns to the slot owner.
module sdram_slot_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 23,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clkref,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_din,
    input  logic [NUM_REQ*2-1:0]  req_ds,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [DW-1:0]         resp_data,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_din,
    output logic [1:0]            mem_ds,
    input  logic [DW-1:0]         mem_dout,
    input  logic                  mem_dout_valid,
    output logic                  idle_slot,
    output logic                  err_lost
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        RD_DONE
    } state_t;

    state_t        state;
    logic          clkref_r;
    logic          slot_edge;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic [IW-1:0] rr_next;
    logic          has_winner;

    logic [AW-1:0] addr_arr [NUM_REQ];
    logic [DW-1:0] din_arr  [NUM_REQ];
    logic [1:0]    ds_arr   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign din_arr[i]  = req_din[i*DW +: DW];
        assign ds_arr[i]   = req_ds[i*2 +: 2];
    end

    assign slot_edge = clkref & ~clkref_r;

    // Port 0 wins outright; otherwise scan 1..NUM_REQ-1 starting at rr_ptr, wrapping back to 1.
    always_comb begin : arbitrate
        int cand;
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        winner     = '0;
        has_winner = 1'b0;
        cand       = 0;
        if (req_valid[0]) begin
            has_winner = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_REQ) cand = cand - (NUM_REQ - 1);
                if (!has_winner && req_valid[IW'(cand)]) begin
                    has_winner = 1'b1;
                    winner     = IW'(cand);
                end
            end
        end
    end

    assign rr_next = (int'(winner) == NUM_REQ - 1) ? IW'(1) : winner + IW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clkref_r   <= 1'b0;
            rr_ptr     <= IW'(1);
            owner      <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_ds     <= '0;
            idle_slot  <= 1'b0;
            err_lost   <= 1'b0;
        end else begin
            clkref_r   <= clkref;
            req_ready  <= '0;
            resp_valid <= '0;
            idle_slot  <= 1'b0;

            if (state == RD_WAIT && mem_dout_valid) begin
                resp_data  <= mem_dout;
                resp_valid <= NUM_REQ'(1) << owner;
                state      <= RD_DONE;
            end

            // NOTE: this later assignment to state overrides RD_DONE above, so a slot edge always
            // starts the new slot while the coincident read still returns to the old owner.
            if (slot_edge) begin
                if (state == RD_WAIT && !mem_dout_valid) err_lost <= 1'b1;
                if (has_winner) begin
                    req_ready <= NUM_REQ'(1) << winner;
                    mem_rd    <= ~req_we[winner];
                    mem_wr    <= req_we[winner];
                    mem_addr  <= addr_arr[winner];
                    mem_din   <= din_arr[winner];
                    mem_ds    <= ds_arr[winner];
                    owner     <= winner;
                    state     <= req_we[winner] ? WR : RD_WAIT;
                    if (winner != '0) rr_ptr <= rr_next;
                end else begin
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                    idle_slot <= 1'b1;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Scoreboard bench for sdram_slot_arbiter: a transaction-level model predicts grants,
// read returns and err_lost; a negedge monitor pops and compares what the DUT presents.
module tb_sdram_slot_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            clkref = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_din = '0;
    logic [N*2-1:0]  req_ds = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            mem_rd, mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [1:0]      mem_ds;
    logic [DW-1:0]   mem_dout = '0;
    logic            mem_dout_valid = 1'b0;
    logic            idle_slot;
    logic            err_lost;

    sdram_slot_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .clkref(clkref),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_din(req_din), .req_ds(req_ds), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_ds(mem_ds), .mem_dout(mem_dout),
        .mem_dout_valid(mem_dout_valid), .idle_slot(idle_slot), .err_lost(err_lost)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int            cyc;
        int            port;   // -1 means idle slot
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [1:0]    ds;
    } grant_t;

    typedef struct {
        int            cyc;
        int            port;
        logic [DW-1:0] data;
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Requester-side state
    logic          pv   [N];
    logic          pwe  [N];
    logic [AW-1:0] paddr[N];
    logic [DW-1:0] pdin [N];
    logic [1:0]    pds  [N];
    int            drop_port = -1;
    bit            rand_mode = 0;

    // Reference-model state
    int   m_rr = 1;
    logic m_ck_prev = 1'b0;
    bit   rd_pend = 0;
    bit   rd_done = 0;
    int   rd_owner = 0;
    int   err_cyc = 0;
    logic cur_rd = 1'b0;
    logic cur_wr = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pv[i];
            req_we[i]            = pwe[i];
            req_addr[i*AW +: AW] = paddr[i];
            req_din[i*DW +: DW]  = pdin[i];
            req_ds[i*2 +: 2]     = pds[i];
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] ds);
        pv[p] = 1'b1; pwe[p] = we; paddr[p] = a; pdin[p] = d; pds[p] = ds;
    endtask

    // Slot-level model: called with the inputs the DUT will sample at cycle s.
    task automatic model(input logic ck, input logic dv, input logic [DW-1:0] dd);
        int s;
        int w;
        grant_t g;
        resp_t r;
        s = cyc + 1;
        if (dv && rd_pend && !rd_done) begin
            r.cyc = s; r.port = rd_owner; r.data = dd;
            rq.push_back(r);
            rd_done = 1;
        end
        if (ck && !m_ck_prev) begin
            if (rd_pend && !rd_done && err_cyc == 0) err_cyc = s;
            rd_pend = 0;
            w = -1;
            if (pv[0]) w = 0;
            else begin
                for (int k = 0; k < N - 1; k++) begin
                    int p;
                    p = (m_rr - 1 + k) % (N - 1) + 1;
                    if (w < 0 && pv[p]) w = p;
                end
            end
            if (w > 0) m_rr = w % (N - 1) + 1;
            g.cyc = s; g.port = w;
            g.we = 1'b0; g.addr = '0; g.din = '0; g.ds = '0;
            if (w >= 0) begin
                g.we = pwe[w]; g.addr = paddr[w]; g.din = pdin[w]; g.ds = pds[w];
                drop_port = w;
                if (!pwe[w]) begin
                    rd_pend = 1; rd_done = 0; rd_owner = w;
                end
            end
            gq.push_back(g);
        end
        m_ck_prev = ck;
    endtask

    task automatic tick(input logic ck, input logic dv, input logic [DW-1:0] dd);
        @(posedge clk);
        #1;
        if (drop_port >= 0) begin
            pv[drop_port] = 1'b0;
            drop_port = -1;
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom), AW'($urandom), DW'($urandom), 2'($urandom));
                else if (pv[i] && $urandom_range(0, 49) == 0)
                    pv[i] = 1'b0;
            end
        end
        clkref = ck;
        mem_dout_valid = dv;
        mem_dout = dd;
        drive_ports();
        model(ck, dv, dd);
    endtask

    // One slot of len cycles; dv_at selects the cycle offset of the mem_dout_valid pulse.
    task automatic slot(input int len, input int dv_at, input logic [DW-1:0] dd);
        for (int t = 0; t < len; t++)
            tick(t < (len + 1) / 2, t == dv_at, (t == dv_at) ? dd : DW'($urandom));
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        reset = 1'b1;
        gq.delete(); rq.delete();
        m_rr = 1; m_ck_prev = 1'b0; rd_pend = 0; rd_done = 0; err_cyc = 0;
        cur_rd = 1'b0; cur_wr = 1'b0; drop_port = -1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0);
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        clkref = 1'b0; mem_dout_valid = 1'b0;
        drive_ports();
        #1;
        check("reset_ctrl", {req_ready, resp_valid, mem_rd, mem_wr, mem_ds, idle_slot, err_lost}, '0);
        check("reset_data", {resp_data, mem_addr}, '0);
        check("reset_din", mem_din, '0);
        repeat (hold) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, idle slot or read return.
    initial begin
        grant_t g;
        resp_t  r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                while (gq.size() > 0 && gq[0].cyc < cyc) begin
                    check("grant_cycle", cyc, gq[0].cyc);
                    g = gq.pop_front();
                    cur_rd = (g.port >= 0) && !g.we;
                    cur_wr = (g.port >= 0) && g.we;
                end
                if (req_ready != '0 || idle_slot) begin
                    if (gq.size() == 0 || gq[0].cyc != cyc) begin
                        check("grant_cycle", cyc, (gq.size() > 0) ? gq[0].cyc : -1);
                    end else begin
                        g = gq.pop_front();
                        if (g.port < 0) begin
                            check("idle_req_ready", req_ready, '0);
                            check("idle_slot", idle_slot, 1);
                            cur_rd = 1'b0; cur_wr = 1'b0;
                        end else begin
                            check("req_ready", req_ready, N'(1) << g.port);
                            check("grant_idle_slot", idle_slot, 0);
                            check("mem_addr", mem_addr, g.addr);
                            check("mem_din", mem_din, g.din);
                            check("mem_ds", mem_ds, g.ds);
                            cur_rd = !g.we; cur_wr = g.we;
                        end
                    end
                end
                check("mem_rd", mem_rd, cur_rd);
                check("mem_wr", mem_wr, cur_wr);

                while (rq.size() > 0 && rq[0].cyc < cyc) begin
                    check("resp_cycle", cyc, rq[0].cyc);
                    r = rq.pop_front();
                end
                if (resp_valid != '0) begin
                    if (rq.size() == 0 || rq[0].cyc != cyc) begin
                        check("resp_cycle", cyc, (rq.size() > 0) ? rq[0].cyc : -1);
                    end else begin
                        r = rq.pop_front();
                        check("resp_valid", resp_valid, N'(1) << r.port);
                        check("resp_data", resp_data, r.data);
                    end
                end
                check("err_lost", err_lost, (err_cyc != 0 && cyc >= err_cyc));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pdin[i] = '0; pds[i] = '0;
        end
        do_reset(3);

        // Port 0 beats 1 and 2; then 1 wins from rr_ptr=1
        set_req(0, 1'b0, 23'h000100, 16'h0000, 2'b11);
        set_req(1, 1'b0, 23'h000200, 16'h0000, 2'b01);
        set_req(2, 1'b0, 23'h000300, 16'h0000, 2'b10);
        slot(6, 3, 16'h1111);
        slot(6, 2, 16'h2222);
        slot(6, 3, 16'h3333);

        // Round-robin from a fresh rr_ptr: expected order 1,2,3,1,2,3
        do_reset(2);
        for (int j = 0; j < 6; j++) begin
            for (int p = 1; p < N; p++)
                if (!pv[p]) set_req(p, 1'b1, AW'($urandom), DW'($urandom), 2'b11);
            slot(5, -1, '0);
        end
        for (int p = 0; p < N; p++) pv[p] = 1'b0;

        // Read return to port 2
        set_req(2, 1'b0, 23'h001234, 16'h0000, 2'b11);
        slot(8, 4, 16'hBEEF);

        // Idle slot
        slot(5, -1, '0);

        // Lost read data, then sticky err_lost
        set_req(3, 1'b0, 23'h0000AA, 16'h0000, 2'b11);
        slot(5, -1, '0);
        slot(5, -1, '0);
        slot(4, -1, '0);

        // Reset while a read waits for data
        set_req(1, 1'b0, 23'h000055, 16'h0000, 2'b11);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        do_reset(2);

        // Data arriving on the same cycle as the next slot edge
        set_req(1, 1'b0, 23'h000777, 16'h0000, 2'b11);
        slot(6, -1, '0);
        set_req(2, 1'b1, 23'h000888, 16'h5A5A, 2'b01);
        slot(6, 0, 16'hC0DE);
        slot(4, -1, '0);

        // Randomized traffic
        rand_mode = 1;
        for (int j = 0; j < 300; j++) begin
            int len;
            len = $urandom_range(3, 9);
            slot(len, $urandom_range(0, len), DW'($urandom));
        end
        rand_mode = 0;
        for (int p = 0; p < N; p++) pv[p] = 1'b0;
        slot(4, -1, '0);
        repeat (3) tick(1'b0, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("grant_queue_drained", gq.size(), 0);
        check("resp_queue_drained", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
